// File: rtl/multicycle_proc_param.sv
// ---------------------------------------------------------------------------
// multicycle_proc_param
//   Parametrised multicycle processor. Fetches one instruction from DIN per
//   Run request, executes it over one to three timesteps on a single shared
//   bus and raises Done during the last timestep.
//
//   Instruction word: op = IR[top 3 bits], X = next REG_BITS bits,
//   Y = following REG_BITS bits; lower bits are ignored.
//     000 mv   Rx,Ry    001 mvi  Rx,#D   010 add  Rx,Ry   011 sub  Rx,Ry
//     100 and  Rx,Ry    101 mvnz Rx,Ry   110 adc/NOP      111 NOP
//
//   Optional feature macro: PROC_ADC_EN
//     defined   : op 110 is adc Rx,Ry (Rx <= Rx + Ry + C), timed like add
//     undefined : op 110 behaves as NOP
//
// Parameters
//   W        datapath / instruction width (W >= 3 + 2*REG_BITS)
//   REG_BITS register index width, 2**REG_BITS general registers
//
// Ports
//   Clock    in   rising-edge clock
//   Reset    in   asynchronous active-high reset
//   DIN      in   instruction word in T0, immediate for mvi in T1
//   Run      in   start request, only honoured while idle (T0)
//   Done     out  high during the final timestep of an instruction
//   BusWires out  shared bus value, 0 while no source drives it
// ---------------------------------------------------------------------------
// Timestep FSM
//   state | meaning
//   T0    | idle, waiting for Run; IR loads from DIN on the Run edge
//   T1    | first execute step (mv/mvi/mvnz/NOP finish here; ALU ops load A)
//   T2    | ALU ops: Ry on bus, G <= A op Ry, flags update
//   T3    | ALU ops: G on bus, Rx <= G, Done
// ---------------------------------------------------------------------------
module multicycle_proc_param #(
    parameter int W        = 16,
    parameter int REG_BITS = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [W-1:0] DIN,
    input  logic         Run,
    output logic         Done,
    output logic [W-1:0] BusWires
);
    localparam int NREGS = 2**REG_BITS;
    // only the decoded fields of the instruction are kept
    localparam int IRW   = 3 + 2*REG_BITS;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;
`ifdef PROC_ADC_EN
    localparam logic [2:0] OP_ADC  = 3'b110;
`endif

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

    typedef enum logic [2:0] {
        BUS_NONE,
        BUS_DIN,
        BUS_RX,
        BUS_RY,
        BUS_G
    } bus_sel_t;

    tstep_t         tstep_q, tstep_d;
    logic [IRW-1:0] ir;
    logic [W-1:0]   regs [NREGS];
    logic [W-1:0]   a_reg, g_reg;
    logic           z_flag, c_flag;

    logic [2:0]          op;
    logic [REG_BITS-1:0] rx, ry;

    assign op = ir[IRW-1 -: 3];
    assign rx = ir[IRW-4 -: REG_BITS];
    assign ry = ir[REG_BITS-1:0];

    bus_sel_t bus_sel;
    logic     ir_in, a_in, g_in, rx_wr;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        tstep_d = tstep_q;
        bus_sel = BUS_NONE;
        ir_in   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        rx_wr   = 1'b0;
        Done    = 1'b0;
        case (tstep_q)
            T0: begin
                if (Run) begin
                    ir_in   = 1'b1;
                    tstep_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        bus_sel = BUS_RY;
                        rx_wr   = 1'b1;
                        Done    = 1'b1;
                        tstep_d = T0;
                    end
                    OP_MVI: begin
                        bus_sel = BUS_DIN;
                        rx_wr   = 1'b1;
                        Done    = 1'b1;
                        tstep_d = T0;
                    end
`ifdef PROC_ADC_EN
                    OP_ADD, OP_SUB, OP_AND, OP_ADC: begin
`else
                    OP_ADD, OP_SUB, OP_AND: begin
`endif
                        bus_sel = BUS_RX;
                        a_in    = 1'b1;
                        tstep_d = T2;
                    end
                    OP_MVNZ: begin
                        bus_sel = BUS_RY;
                        rx_wr   = ~z_flag;
                        Done    = 1'b1;
                        tstep_d = T0;
                    end
                    default: begin
                        Done    = 1'b1;
                        tstep_d = T0;
                    end
                endcase
            end
            T2: begin
                bus_sel = BUS_RY;
                g_in    = 1'b1;
                tstep_d = T3;
            end
            T3: begin
                bus_sel = BUS_G;
                rx_wr   = 1'b1;
                Done    = 1'b1;
                tstep_d = T0;
            end
            default: tstep_d = T0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared bus
    // ------------------------------------------------------------------
    always_comb begin
        case (bus_sel)
            BUS_DIN: BusWires = DIN;
            BUS_RX:  BusWires = regs[rx];
            BUS_RY:  BusWires = regs[ry];
            BUS_G:   BusWires = g_reg;
            default: BusWires = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU: A op Bus. Subtraction is A + ~B + 1 so the carry-out is the
    // inverted borrow (set when A >= B unsigned).
    // ------------------------------------------------------------------
    logic [W:0]   alu_sum;
    logic [W-1:0] alu_res;
    logic         alu_c;

    always_comb begin
        alu_sum = '0;
        alu_res = '0;
        alu_c   = c_flag;
        case (op)
            OP_SUB: begin
                alu_sum = {1'b0, a_reg} + {1'b0, ~BusWires} + {{W{1'b0}}, 1'b1};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
            end
            OP_AND: begin
                alu_res = a_reg & BusWires;
            end
`ifdef PROC_ADC_EN
            OP_ADC: begin
                alu_sum = {1'b0, a_reg} + {1'b0, BusWires} + {{W{1'b0}}, c_flag};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
            end
`endif
            default: begin
                alu_sum = {1'b0, a_reg} + {1'b0, BusWires};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tstep_q <= T0;
            ir      <= '0;
            a_reg   <= '0;
            g_reg   <= '0;
            z_flag  <= 1'b0;
            c_flag  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            tstep_q <= tstep_d;
            if (ir_in) begin
                ir <= DIN[W-1 -: IRW];
            end
            if (a_in) begin
                a_reg <= BusWires;
            end
            if (g_in) begin
                g_reg  <= alu_res;
                z_flag <= (alu_res == '0);
                c_flag <= alu_c;
            end
            if (rx_wr) begin
                regs[rx] <= BusWires;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_proc_param.sv
// ---------------------------------------------------------------------------
// tb_multicycle_proc_param
//   Bench for multicycle_proc_param (W=16, REG_BITS=3). An instruction-level
//   model predicts, for every cycle, the value on BusWires and Done; a single
//   compare process checks both on the falling edge. A directed section
//   reproduces the documented scenarios with literal expectations, then a
//   random section issues instructions with random Run noise and resets.
// ---------------------------------------------------------------------------
module tb_multicycle_proc_param;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] DIN   = '0;
    logic        Run   = 1'b0;
    logic        Done;
    logic [15:0] BusWires;

    multicycle_proc_param #(.W(16), .REG_BITS(3)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .DIN      (DIN),
        .Run      (Run),
        .Done     (Done),
        .BusWires (BusWires)
    );

    always #5 Clock = ~Clock;

    int n_total = 0;
    int n_bad   = 0;

    // model state
    logic [15:0] m_r [8];
    logic        m_z, m_c;

    // per-cycle expectation consumed by the compare process
    logic        chk_en   = 1'b0;
    logic [15:0] exp_bus  = '0;
    logic        exp_done = 1'b0;

    int          cyc = 0;
    int          done_cyc = 0;
    int          fetch_cyc = 0;
    logic [15:0] last_done_bus = '0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge Clock) cyc++;

    always @(negedge Clock) begin
        if (chk_en) begin
            check("done", {15'd0, Done}, {15'd0, exp_done});
            check("bus", BusWires, exp_bus);
            if (Done === 1'b1) begin
                last_done_bus = BusWires;
                done_cyc      = cyc;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    // one clock cycle: drive inputs and the expected outputs for it
    task automatic step(input logic [15:0] din, input logic run,
                        input logic [15:0] eb, input logic ed);
        DIN      = din;
        Run      = run;
        exp_bus  = eb;
        exp_done = ed;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        step(16'($urandom), 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        exp_bus  = '0;
        exp_done = 1'b0;
        #1;
        check("rst_done", {15'd0, Done}, 16'd0);
        check("rst_bus", BusWires, 16'h0000);
        model_clear();
        Run = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // Issue one instruction. abort_at = 1..3 resets the core at the start of
    // that timestep (if the instruction reaches it); 0 = run to completion.
    task automatic exec(input logic [15:0] instr, input logic [15:0] imm,
                        input bit hold, input int abort_at);
        logic [2:0]  op;
        int          x, y;
        logic [15:0] a, b, res;
        logic [16:0] wide;
        logic        nc;
        op = instr[15:13];
        x  = int'(instr[12:10]);
        y  = int'(instr[9:7]);
        fetch_cyc = cyc;
        step(instr, 1'b1, 16'h0000, 1'b0);
        if (abort_at == 1) begin
            do_reset();
            return;
        end
        case (op)
            3'b000: begin
                a = m_r[y];
                step(16'($urandom), hold ? 1'b1 : 1'($urandom), a, 1'b1);
                m_r[x] = a;
            end
            3'b001: begin
                step(imm, hold ? 1'b1 : 1'($urandom), imm, 1'b1);
                m_r[x] = imm;
            end
            3'b101: begin
                a = m_r[y];
                step(16'($urandom), hold ? 1'b1 : 1'($urandom), a, 1'b1);
                if (!m_z) m_r[x] = a;
            end
`ifdef PROC_ADC_EN
            3'b010, 3'b011, 3'b100, 3'b110: begin
`else
            3'b010, 3'b011, 3'b100: begin
`endif
                a = m_r[x];
                b = m_r[y];
                step(16'($urandom), hold ? 1'b1 : 1'($urandom), a, 1'b0);
                if (abort_at == 2) begin
                    do_reset();
                    return;
                end
                step(16'($urandom), hold ? 1'b1 : 1'($urandom), b, 1'b0);
                if (abort_at == 3) begin
                    do_reset();
                    return;
                end
                nc = m_c;
                case (op)
                    3'b010: begin wide = 17'(a) + 17'(b);          res = wide[15:0]; nc = wide[16]; end
                    3'b011: begin res = a - b;                      nc = (a >= b); end
                    3'b100: begin res = a & b; end
                    default: begin wide = 17'(a) + 17'(b) + 17'(m_c); res = wide[15:0]; nc = wide[16]; end
                endcase
                step(16'($urandom), hold ? 1'b1 : 1'($urandom), res, 1'b1);
                m_r[x] = res;
                m_z    = (res == 16'h0000);
                m_c    = nc;
            end
            default: begin
                step(16'($urandom), hold ? 1'b1 : 1'($urandom), 16'h0000, 1'b1);
            end
        endcase
    endtask

    int prev_done;

    initial begin
        model_clear();
        #2;
        check("reset_done", {15'd0, Done}, 16'd0);
        check("reset_bus", BusWires, 16'h0000);
        @(posedge Clock);
        #1;
        Reset  = 1'b0;
        chk_en = 1'b1;
        idle();

        // 1: reset during T2 of add aborts it; mv R2,R0 afterwards reads 0
        exec(16'h2000, 16'h0005, 1'b0, 0);
        exec(16'h4080, 16'h0000, 1'b0, 2);
        idle();
        exec(16'h0800, 16'h0000, 1'b0, 0);
        check("lit_mv_after_rst", last_done_bus, 16'h0000);

        // 2: mvi R0,#5 ; mvi R1,#3
        exec(16'h2000, 16'h0005, 1'b0, 0);
        check("lit_mvi_r0", last_done_bus, 16'h0005);
        check("lit_mvi_lat", 16'(done_cyc - fetch_cyc), 16'd1);
        idle();
        exec(16'h2400, 16'h0003, 1'b0, 0);
        check("lit_mvi_r1", last_done_bus, 16'h0003);

        // 3: add R0,R1 -> 8, three cycles after fetch
        exec(16'h4080, 16'h0000, 1'b0, 0);
        check("lit_add_bus", last_done_bus, 16'h0008);
        check("lit_add_lat", 16'(done_cyc - fetch_cyc), 16'd3);

        // 4: R0=5, R1=3; sub R1,R0; sub R1,R1; mvnz R2,R0; mv R3,R2
        exec(16'h2000, 16'h0005, 1'b0, 0);
        exec(16'h2400, 16'h0003, 1'b0, 0);
        exec(16'h6400, 16'h0000, 1'b0, 0);
        check("lit_sub_neg", last_done_bus, 16'hFFFE);
        exec(16'h6480, 16'h0000, 1'b0, 0);
        check("lit_sub_self", last_done_bus, 16'h0000);
        exec(16'hA800, 16'h0000, 1'b0, 0);
        check("lit_mvnz_lat", 16'(done_cyc - fetch_cyc), 16'd1);
        exec(16'h0D00, 16'h0000, 1'b0, 0);
        check("lit_mvnz_kept", last_done_bus, 16'h0000);

        // 5: Run held high: mvi R3,#FFFF; add R3,R3; and R3,R0
        exec(16'h2C00, 16'hFFFF, 1'b1, 0);
        exec(16'h4D80, 16'h0000, 1'b1, 0);
        check("lit_dbl", last_done_bus, 16'hFFFE);
        prev_done = done_cyc;
        exec(16'h8C00, 16'h0000, 1'b1, 0);
        check("lit_and", last_done_bus, 16'h0004);
        check("lit_spacing", 16'(done_cyc - prev_done), 16'd4);
        idle();

        // 6: op 110 with R0=FFFF, R1=1 after add R0,R1 (C=1)
        exec(16'h2000, 16'hFFFF, 1'b0, 0);
        exec(16'h2400, 16'h0001, 1'b0, 0);
        exec(16'h4080, 16'h0000, 1'b0, 0);
        check("lit_add_wrap", last_done_bus, 16'h0000);
        exec(16'hC080, 16'h0000, 1'b0, 0);
        exec(16'h0800, 16'h0000, 1'b0, 0);
`ifdef PROC_ADC_EN
        check("lit_adc", last_done_bus, 16'h0002);
`else
        check("lit_op110_nop", last_done_bus, 16'h0000);
`endif

        // random instructions, random Run noise, occasional aborts
        for (int n = 0; n < 500; n++) begin
            logic [15:0] instr, imm;
            int          ab;
            instr = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       imm = 16'h0000;
                1:       imm = 16'hFFFF;
                default: imm = 16'($urandom);
            endcase
            ab = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 3)) : 0;
            exec(instr, imm, 1'($urandom), ab);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
